mc_controller: RTL

Parametrised multicycle MIPS control unit: a next-generation main FSM plus ALU decoder for the multicycle datapath. It adds memory wait-state handshaking, a bounded wait timeout, an extended instruction set (bne, addi, andi, ori, j) and a configurable ALU-control width. It sits between the instruction register and the datapath, driving all enables and muxes every cycle.

---
 rtl/mc_ctrl_pkg.sv | 57 +++++
 rtl/mc_aludec.sv | 50 +++++
 rtl/mc_controller.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared state, opcode, funct and ALU encodings for mc_controller.
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_LOGIEX  = 4'd10;
    localparam logic [3:0] S_IMMWB   = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;
    localparam logic [3:0] S_ERROR   = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_FUNCT = 3'd2,
        ALUOP_AND   = 3'd3,
        ALUOP_OR    = 3'd4
    } aluop_e;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage
`default_nettype wire

// File: rtl/mc_aludec.sv
`default_nettype none
// ============================================================================
// Module   : mc_aludec
// Purpose  : Combinational aluop/funct to alucontrol decode, zero-extended.
// Revision : 1.0 - initial release
// ============================================================================
module mc_aludec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [2:0]           aluop,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alucontrol
);

    logic [3:0] w_alu4;

    always_comb begin
        w_alu4 = ALU_ADD;
        case (aluop)
            ALUOP_ADD: w_alu4 = ALU_ADD;
            ALUOP_SUB: w_alu4 = ALU_SUB;
            ALUOP_AND: w_alu4 = ALU_AND;
            ALUOP_OR:  w_alu4 = ALU_OR;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  w_alu4 = ALU_ADD;
                    FN_SUB:  w_alu4 = ALU_SUB;
                    FN_AND:  w_alu4 = ALU_AND;
                    FN_OR:   w_alu4 = ALU_OR;
                    FN_SLT:  w_alu4 = ALU_SLT;
                    FN_NOR:  w_alu4 = ALU_NOR;
                    default: w_alu4 = ALU_ADD;
                endcase
            end
            default: w_alu4 = ALU_ADD;
        endcase
    end

    generate
        if (ALUCTRL_W > 4) begin : g_ext
            assign alucontrol = {{(ALUCTRL_W-4){1'b0}}, w_alu4};
        end else begin : g_exact
            assign alucontrol = w_alu4;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Purpose  : Multicycle MIPS main FSM with memory wait handshake and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 4,
    parameter int WAIT_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 memreq,
    output logic                 memwrite,
    output logic                 pcen,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic                 iord,
    output logic                 memtoreg,
    output logic                 regdst,
    output logic                 extop,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 buserr,
    output logic [3:0]           state
);

    localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             buserr_q, buserr_d;

    logic       w_pcwrite;
    logic       w_irwrite;
    logic       w_branch;
    logic       w_bne_sel;
    logic       w_timeout;
    logic [2:0] w_aluop;

    // Moore decode; the unlisted default aluop (AND) yields alucontrol 0
    always_comb begin
        memreq    = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        iord      = 1'b0;
        memtoreg  = 1'b0;
        regdst    = 1'b0;
        extop     = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        w_pcwrite = 1'b0;
        w_irwrite = 1'b0;
        w_branch  = 1'b0;
        w_bne_sel = 1'b0;
        w_aluop   = ALUOP_AND;
        case (state_q)
            S_FETCH: begin
                memreq    = 1'b1;
                alusrcb   = 2'b01;
                w_aluop   = ALUOP_ADD;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                w_aluop = ALUOP_ADD;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_aluop = ALUOP_ADD;
            end
            S_MEMRD: begin
                memreq = 1'b1;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memreq   = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca   = 1'b1;
                pcsrc     = 2'b01;
                w_aluop   = ALUOP_SUB;
                w_branch  = 1'b1;
                w_bne_sel = op[0];
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_aluop = ALUOP_ADD;
            end
            S_LOGIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                extop   = 1'b1;
                w_aluop = op[0] ? ALUOP_OR : ALUOP_AND;
            end
            S_IMMWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset holds the FETCH decode but must not let IR or PC load
    assign irwrite = w_irwrite & reset_n;
    assign pcen    = (w_pcwrite | (w_branch & (zero ^ w_bne_sel))) & reset_n;

    assign w_timeout = (WAIT_LIMIT != 0) && memreq && !mem_ready && (wait_cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE:        state_d = S_RTYPEEX;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_ADDI:         state_d = S_ADDIEX;
                    OP_ANDI, OP_ORI: state_d = S_LOGIEX;
                    OP_J:            state_d = S_JUMP;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_RTYPEEX: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_IMMWB;
            S_LOGIEX:  state_d = S_IMMWB;
            S_IMMWB:   state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_FETCH;
        endcase
        if (w_timeout) begin
            state_d = S_ERROR;
        end
    end

    // Counter only runs while parked in one memory state; any transition clears it
    always_comb begin
        wait_cnt_d = '0;
        if (memreq && !mem_ready && (state_d == state_q)) begin
            wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        buserr_d = buserr_q | (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            buserr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            buserr_q   <= buserr_d;
        end
    end

    assign buserr = buserr_q;
    assign state  = state_q;

    mc_aludec #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_aludec (
        .aluop      (w_aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
`default_nettype wire
